// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: front-end sequencer for the 5-stage pipeline.
// Decides PC / IF-ID advance and drives stall/flush for the ID slice:
// load-use bubbles, taken-branch squash, RET fetch hold and halt drain.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int unsigned BR_FLUSH_CYC = 2,  // 1..7
    parameter int unsigned DRAIN_CYC    = 4   // 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] id_instr,
    input  logic        ex_MemRead,
    input  logic [3:0]  ex_dst,
    input  logic        br_taken,
    input  logic        ret_done,
    input  logic        hlt_req,
    output logic        pc_write,
    output logic        ID_Dwrite,
    output logic        stall,
    output logic        flush,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [2:0] {
        StRun, StLdStall, StBrFlush, StRetWait, StDrain, StHalt
    } state_e;

    // Counter holds the number of remaining cycles in BRFLUSH / DRAIN, including the current one.
    localparam logic [3:0] BrLoad    = 4'(BR_FLUSH_CYC - 1);
    localparam logic [3:0] DrainLoad = 4'(DRAIN_CYC - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] br_rem;
    logic       halted_q;

    logic [3:0] opcode, rd, rs;
    logic [3:0] src_a, src_b;
    logic       use_a, use_b;
    logic       lu;
    logic       pc_c, idw_c, stall_c, flush_c;

    assign opcode = id_instr[15:12];
    assign rd     = id_instr[11:8];
    assign rs     = id_instr[7:4];

    // Source registers read by the instruction in ID, and the load-use check against EX.
    always_comb begin
        use_a = 1'b0;
        use_b = 1'b0;
        src_a = rs;
        src_b = id_instr[3:0];
        case (opcode)
            4'h0, 4'h1, 4'h2, 4'h3: begin
                use_a = 1'b1;
                use_b = 1'b1;
            end
            4'h4, 4'h5, 4'h6, 4'h7: use_a = 1'b1;
            4'h8: begin
                use_a = 1'b1;
                src_a = 4'd14;
            end
            4'h9: begin
                use_a = 1'b1;
                src_a = 4'd14;
                use_b = 1'b1;
                src_b = rd;
            end
            4'hA, 4'hB: begin
                use_a = 1'b1;
                src_a = rd;
            end
            4'hD, 4'hE: begin
                use_a = 1'b1;
                src_a = 4'd15;
            end
            default: ;
        endcase
        lu = ex_MemRead && (ex_dst != 4'd0) &&
             ((use_a && (ex_dst == src_a)) || (use_b && (ex_dst == src_b)));
    end

    // Next state and combinational pipeline controls.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_c    = 1'b1;
        idw_c   = 1'b1;
        stall_c = 1'b0;
        flush_c = 1'b0;
        br_rem  = br_taken ? BrLoad : (cnt_q - 4'd1);
        unique case (state_q)
            StRun: begin
                if (br_taken) begin
                    flush_c = 1'b1;
                    if (BrLoad != 4'd0) begin
                        state_d = StBrFlush;
                        cnt_d   = BrLoad;
                    end
                end else if (hlt_req) begin
                    pc_c    = 1'b0;
                    idw_c   = 1'b0;
                    stall_c = 1'b1;
                    if (DrainLoad != 4'd0) begin
                        state_d = StDrain;
                        cnt_d   = DrainLoad;
                    end else begin
                        state_d = StHalt;
                    end
                end else if (lu) begin
                    pc_c    = 1'b0;
                    idw_c   = 1'b0;
                    stall_c = 1'b1;
                    state_d = StLdStall;
                end else if (opcode == 4'hE) begin
                    state_d = StRetWait;
                end
            end
            StLdStall: state_d = StRun;
            StBrFlush: begin
                // A new taken branch restarts the full squash window.
                flush_c = 1'b1;
                cnt_d   = br_rem;
                if (br_rem == 4'd0) state_d = StRun;
            end
            StRetWait: begin
                pc_c    = ret_done;
                idw_c   = 1'b0;
                flush_c = 1'b1;
                if (ret_done) state_d = StRun;
            end
            StDrain: begin
                pc_c    = 1'b0;
                idw_c   = 1'b0;
                stall_c = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = StHalt;
            end
            StHalt: begin
                pc_c    = 1'b0;
                idw_c   = 1'b0;
                stall_c = 1'b1;
            end
            default: state_d = StRun;
        endcase
    end

    // State, drain/flush counter and registered halted flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StRun;
            cnt_q    <= 4'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= (state_d == StHalt);
        end
    end

    // Reset forces the idle controls even while hazardous inputs are present.
    assign pc_write  = !rst ? 1'b1 : pc_c;
    assign ID_Dwrite = !rst ? 1'b1 : idw_c;
    assign stall     = rst & stall_c;
    assign flush     = rst & flush_c;
    assign halted    = halted_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    // Saturating stall / flush cycle counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 16'h0000;
    assign flush_cnt = 16'h0000;
`endif

endmodule
